// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM request/response controller.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;
  localparam int RSP_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry response FIFO holding {last, data} pairs captured from the SRAM.
module sram_rsp_fifo #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pushLast_i,
  input  logic [DATA_W-1:0] pushData_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] headData_o,
  output logic              headLast_o,
  output logic [1:0]        count_o
);

  logic [DATA_W:0] entry_q [2];
  logic            wrPtr_q;
  logic            rdPtr_q;
  logic [1:0]      count_q;

  // Storage, pointers and occupancy; the controller never pushes into a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wrPtr_q    <= 1'b0;
      rdPtr_q    <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push_i) begin
        entry_q[wrPtr_q] <= {pushLast_i, pushData_i};
        wrPtr_q          <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign headData_o = entry_q[rdPtr_q][DATA_W-1:0];
  assign headLast_o = entry_q[rdPtr_q][DATA_W];
  assign count_o    = count_q;

endmodule

// File: rtl/sram_ctrl.sv
// Burst front end for a single-port synchronous SRAM with one-cycle read latency.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam logic [2:0] DEPTH_W3 = 3'(RSP_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [ADDR_W-1:0] beatsLeft_q, beatsLeft_d;
  logic              inflight_q, inflight_d;
  logic              inflightLast_q, inflightLast_d;

  logic [1:0]        fifoCount;
  logic [DATA_W-1:0] headData;
  logic              headLast;
  logic              pop;
  logic              issue;
  logic [2:0]        occAfter;

  // A beat leaving this cycle frees its slot, which keeps reads at one per cycle.
  assign rsp_valid = (fifoCount != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign occAfter  = {1'b0, fifoCount} - {2'b00, pop} + {2'b00, inflight_q} + 3'd1;
  assign issue     = (state_q == READ) && (occAfter <= DEPTH_W3);

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      curAddr_q      <= '0;
      beatsLeft_q    <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      curAddr_q      <= curAddr_d;
      beatsLeft_q    <= beatsLeft_d;
      inflight_q     <= inflight_d;
      inflightLast_q <= inflightLast_d;
    end
  end

  // Next-state: accept requests in IDLE, step address and beat count per beat.
  always_comb begin
    state_d        = state_q;
    curAddr_d      = curAddr_q;
    beatsLeft_d    = beatsLeft_q;
    inflight_d     = issue;
    inflightLast_d = issue && (beatsLeft_q == '0);
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          curAddr_d   = req_addr;
          beatsLeft_d = req_len;
          state_d     = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          curAddr_d   = curAddr_q + ADDR_W'(1);
          beatsLeft_d = beatsLeft_q - ADDR_W'(1);
          if (beatsLeft_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      READ: begin
        if (issue) begin
          curAddr_d   = curAddr_q + ADDR_W'(1);
          beatsLeft_d = beatsLeft_q - ADDR_W'(1);
          if (beatsLeft_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes and SRAM strobes; a write never fires while reset is held.
  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = curAddr_q;
    mem_data_in = '0;
    unique case (state_q)
      IDLE:  req_ready = 1'b1;
      WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          mem_we      = rst_n;
          mem_data_in = wdata;
        end
      end
      READ:    ;
      default: ;
    endcase
  end

  sram_rsp_fifo #(.DATA_W(DATA_W)) u_rspFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .pushLast_i (inflightLast_q),
    .pushData_i (mem_data_out),
    .pop_i      (pop),
    .headData_o (headData),
    .headLast_o (headLast),
    .count_o    (fifoCount)
  );

  assign rsp_data = rsp_valid ? headData : '0;
  assign rsp_last = rsp_valid && headLast;
  assign busy     = (state_q != IDLE) || inflight_q || rsp_valid;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural SRAM and a word-array reference.
module tb_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [1:0] req_addr, req_len;
  logic       wdata_valid, wdata_ready;
  logic [3:0] wdata;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [3:0] rsp_data;
  logic [1:0] mem_addr;
  logic [3:0] mem_data_in, mem_data_out;
  logic       mem_we, busy;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } rsp_t;

  logic [3:0] sram   [4];
  logic [3:0] refMem [4];
  logic [3:0] wbuf   [4];
  rsp_t       expQ   [$];

  int asserts      = 0;
  int fails        = 0;
  int cycleCnt     = 0;
  int popCount     = 0;
  int lastPopCycle = 0;
  int acceptCycle  = 0;
  int rspMode      = 0;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wdata        (wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // Synchronous SRAM: registered read, output holds during a write.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_data_in;
    else        mem_data_out   <= sram[mem_addr];
  end

  // Cycle counter used for latency and throughput checks.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Response consumer: always ready, random, or stalled.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rspMode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop the scoreboard on every accepted response beat.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (expQ.size() != 0) checkOutput("busyPending", 32'(busy), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          asserts++;
          fails++;
          $display("[TB] FAIL unexpectedRsp: actual=%0h expected=none", rsp_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("rspData", 32'(rsp_data), 32'(e.data));
          checkOutput("rspLast", 32'(rsp_last), 32'(e.last));
          popCount++;
          lastPopCycle = cycleCnt;
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".reqReady"},   32'(req_ready),   32'd1);
    checkOutput({tag, ".wdataReady"}, 32'(wdata_ready), 32'd0);
    checkOutput({tag, ".rspValid"},   32'(rsp_valid),   32'd0);
    checkOutput({tag, ".rspLast"},    32'(rsp_last),    32'd0);
    checkOutput({tag, ".rspData"},    32'(rsp_data),    32'd0);
    checkOutput({tag, ".memAddr"},    32'(mem_addr),    32'd0);
    checkOutput({tag, ".memWe"},      32'(mem_we),      32'd0);
    checkOutput({tag, ".memDataIn"},  32'(mem_data_in), 32'd0);
    checkOutput({tag, ".busy"},       32'(busy),        32'd0);
  endtask

  // Present a request and return just after the edge that accepted it.
  task automatic sendReq(input logic we, input logic [1:0] addr, input logic [1:0] len, output bit ok);
    int n = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      asserts++;
      fails++;
      $display("[TB] FAIL reqTimeout: actual=no accept expected=accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    acceptCycle = cycleCnt;
  endtask

  task automatic readBurst(input logic [1:0] addr, input logic [1:0] len);
    bit   ok;
    rsp_t e;
    sendReq(1'b0, addr, len, ok);
    if (ok) begin
      for (int i = 0; i <= int'(len); i++) begin
        e.data = refMem[addr + 2'(i)];
        e.last = (i == int'(len));
        expQ.push_back(e);
      end
    end
  endtask

  // stallMode: 0 = always valid, 1 = alternate 1/0, 2 = random gaps.
  task automatic writeBurst(input logic [1:0] addr, input logic [1:0] len, input int stallMode);
    bit         ok;
    bit         v;
    bit         tog = 1'b1;
    int         i = 0;
    int         n = 0;
    logic [1:0] a;
    sendReq(1'b1, addr, len, ok);
    if (!ok) return;
    while (i <= int'(len) && n < 100) begin
      a = addr + 2'(i);
      case (stallMode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      wdata_valid = v;
      wdata       = wbuf[i];
      @(negedge clk);
      checkOutput("memWe",   32'(mem_we),   32'(v));
      checkOutput("memAddr", 32'(mem_addr), 32'(a));
      if (v) checkOutput("memDataIn", 32'(mem_data_in), 32'(wbuf[i]));
      @(posedge clk);
      if (v) begin
        refMem[a] = wbuf[i];
        i++;
      end
      #1;
      n++;
      tog = ~tog;
    end
    wdata_valid = 1'b0;
    if (i <= int'(len)) begin
      asserts++;
      fails++;
      $display("[TB] FAIL writeTimeout: actual=%0d beats expected=%0d", i, int'(len) + 1);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      asserts++;
      fails++;
      $display("[TB] FAIL drainTimeout: actual=%0d pending expected=0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 1) == 1) begin
      for (int k = 0; k < 4; k++) wbuf[k] = 4'($urandom);
      writeBurst(2'($urandom), 2'($urandom), 2);
    end else begin
      readBurst(2'($urandom), 2'($urandom));
    end
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    int p0;
    int ac;
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rspMode = 2;
    for (int k = 0; k < 4; k++) refMem[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rspMode = 0;

    $display("[TB] single write then read");
    wbuf[0] = 4'hA;
    writeBurst(2'd1, 2'd0, 0);
    readBurst(2'd1, 2'd0);
    ac = acceptCycle;
    p0 = popCount;
    @(negedge clk);
    checkOutput("issueWe",   32'(mem_we),    32'd0);
    checkOutput("issueAddr", 32'(mem_addr),  32'd1);
    checkOutput("lat0Valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat1Valid", 32'(rsp_valid), 32'd0);
    waitDrain();
    checkOutput("singlePops",    32'(popCount - p0),    32'd1);
    checkOutput("singleLatency", 32'(lastPopCycle - ac), 32'd2);

    $display("[TB] full-throughput wrap");
    wbuf[0] = 4'h1; wbuf[1] = 4'h2; wbuf[2] = 4'h3; wbuf[3] = 4'h4;
    writeBurst(2'd2, 2'd3, 0);
    readBurst(2'd0, 2'd3);
    ac = acceptCycle;
    p0 = popCount;
    waitDrain();
    checkOutput("wrapPops",  32'(popCount - p0),     32'd4);
    checkOutput("wrapSpan",  32'(lastPopCycle - ac), 32'd5);

    $display("[TB] backpressure");
    rspMode = 2;
    readBurst(2'd0, 2'd3);
    p0 = popCount;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checkOutput("bpAddrHeld", 32'(mem_addr),  32'd2);
        checkOutput("bpValid",    32'(rsp_valid), 32'd1);
      end
    end
    rspMode = 0;
    waitDrain();
    checkOutput("bpPops", 32'(popCount - p0), 32'd4);

    $display("[TB] write stalls");
    wbuf[0] = 4'h7; wbuf[1] = 4'h8;
    writeBurst(2'd3, 2'd1, 1);
    readBurst(2'd3, 2'd1);
    waitDrain();

    $display("[TB] reset mid-burst");
    sendReq(1'b1, 2'd0, 2'd3, ok);
    wdata_valid = 1'b1;
    wdata = 4'h9;
    @(posedge clk);
    refMem[0] = 4'h9;
    #1;
    wdata = 4'hC;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("resetCycleWe", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wdata_valid = 1'b0;
    @(negedge clk);
    checkResetValues("midReset");
    readBurst(2'd0, 2'd3);
    waitDrain();

    $display("[TB] back-to-back reads");
    rspMode = 1;
    readBurst(2'd1, 2'd2);
    readBurst(2'd2, 2'd3);
    waitDrain();
    @(negedge clk);
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    $display("[TB] random phase");
    repeat (40) applyStimulus();
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  // Watchdog against a wedged run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Request/response front end that owns the single port of the 4-word × 4-bit synchronous SRAM and turns host burst requests into per-cycle SRAM write and read strobes. Host transactions enter through a valid/ready request channel. Write beats come in on a write-data stream, and read beats go out on a back-pressured response stream. The controller accounts for the SRAM's one-cycle registered read latency and for the fact that the SRAM output holds during writes.

## Interface
- `ADDR_W`, default 2: SRAM address width; burst addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 4: SRAM word width.
- `RSP_DEPTH`, fixed at 2: response buffer entries, the minimum for one beat per cycle.

Ports:
- `clk`  in  1  — the single clock; all logic is on the rising edge.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `req_valid`  in  1  — burst request present.
- `req_ready`  out  1  — controller accepts the request; high only in IDLE.
- `req_we`  in  1  — 1 selects a write burst, 0 selects a read burst.
- `req_addr`  in  ADDR_W  — start address.
- `req_len`  in  ADDR_W  — number of beats minus 1 (1..2^ADDR_W beats).
- `wdata_valid`  in  1  /  `wdata_ready`  out  1  /  `wdata`  in  DATA_W  — write-beat stream.
- `rsp_valid`  out  1  /  `rsp_ready`  in  1  /  `rsp_data`  out  DATA_W  /  `rsp_last`  out  1  — read-beat stream.
- `mem_addr`  out  ADDR_W  — to SRAM `addr`.
- `mem_data_in`  out  DATA_W  — to SRAM `data_in`.
- `mem_we`  out  1  — to SRAM `we`.
- `mem_data_out`  in  DATA_W  — from SRAM `data_out`.
- `busy`  out  1  — any state other than IDLE, a read in flight, or a non-empty response buffer.

## Operation
States and transitions:
- **IDLE:** `req_ready`=1. On `req_valid` the controller latches `cur_addr`=`req_addr` and `beats_left`=`req_len`, then moves to WRITE (if `req_we`) or READ.
- **WRITE:** `wdata_ready`=1. Each beat is a cycle with `wdata_valid`=1, and that cycle drives `mem_we`=1, `mem_addr`=`cur_addr`, `mem_data_in`=`wdata`. Each accepted beat increments `cur_addr` (wrapping) and decrements `beats_left`. The last beat returns the controller to IDLE. `wdata_valid`=0 stalls the burst with `mem_we`=0.
- **READ:** a read issues in any cycle where the response-buffer occupancy, plus the in-flight flag, plus 1 is at most RSP_DEPTH. An issue cycle drives `mem_we`=0 and `mem_addr`=`cur_addr`, sets `inflight` for the next cycle, and tags the beat `last` when `beats_left`=0. The last issue returns the controller to IDLE. A new request may be accepted while responses are still draining.
- **Capture:** in the cycle where `inflight`=1, `mem_data_out` and its `last` tag are pushed into the response buffer at the clock edge.
- **Response output:** `rsp_*` show the buffer head. A pop happens on `rsp_valid && rsp_ready`. A push and a pop in the same cycle are both allowed.
- **Address wrap:** `cur_addr` wraps at 2^ADDR_W-1 → 0. A 4-beat burst from address 2 visits 2, 3, 0, 1.
- **Write-then-read ordering:** a read issued in the cycle after a write to the same address returns the new data.
- **Outside WRITE beats:** `mem_we`=0 whenever the controller is not in a WRITE beat. `mem_data_in` is don't-care when `mem_we`=0.

## Timing
- **Reset values:**
  - `req_ready`=1, `wdata_ready`=0, `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0.
  - `mem_addr`=0, `mem_we`=0, `mem_data_in`=0, `busy`=0.
  - `inflight`=0, response buffer empty.
- **Memory outputs:** `mem_*` are combinational from the state registers and `wdata`. `mem_we` is forced to 0 in any cycle with `rst_n`=0, so reset asserted mid-burst never writes.
- **Request acceptance:** a request is accepted at edge E; the first memory beat is driven in the cycle after E.
- **Read latency:** a read issued in cycle N shows `mem_data_out` valid in N+1, and `rsp_valid` rises in N+2.
- **Read throughput:** one beat per cycle while `rsp_ready` is held high. With `rsp_ready` low, at most 2 beats are buffered and no further reads issue.
- **Write throughput:** one beat per cycle while `wdata_valid` is held high.
- **Reset mid-operation:** flushes the response buffer and the in-flight beat and returns the controller to IDLE.

## Structure
- **Package `sram_ctrl_pkg`:** the state enum (IDLE, WRITE, READ) and the default ADDR_W/DATA_W constants.
- **Sub-module `sram_rsp_fifo`:** 2-entry FIFO of {last, data} with push, pop, count, and a synchronous active-low reset.
- **Bench:** instantiates the existing SRAM together with `sram_ctrl`.

## Test plan
- **Single write then read:** write addr 1 = 4'hA, then a read burst at addr 1 with len 0 → one response 4'hA with `rsp_last`=1, `rsp_valid` 2 cycles after issue.
- **Full-throughput wrap:** write a 4-beat burst from addr 2 with data 1, 2, 3, 4, then read a 4-beat burst from addr 0 with `rsp_ready`=1 → responses 3, 4, 1, 2 on consecutive cycles, `last` on the fourth.
- **Backpressure:** read a 4-beat burst with `rsp_ready`=0 for 5 cycles → exactly 2 beats buffered, no further `mem_*` read issues. After `rsp_ready` is released, all 4 beats arrive in order with no loss or duplication.
- **Write stalls:** toggle `wdata_valid` 1, 0, 1, 0 during a 2-beat write → `mem_we` pulses only on the valid cycles and the addresses advance only on accepted beats.
- **Reset mid-burst:** assert `rst_n`=0 during beat 2 of a 4-beat write → `mem_we`=0 in the reset cycle, controller in IDLE, all outputs at reset values. Memory holds only beat 1.
- **Back-to-back requests:** accept a read while the previous read's responses are still pending → order is preserved and `busy` stays high until the last response is popped.
